chipper_injector_param: RTL and testbench

- Parametrised injection stage of the bufferless deflection router. Sits between the input-channel latches and the permutation/arbitration network.
- Buffers locally generated flits in a small queue and passes through the NUM_CH in-flight channels with one register stage.
- Injects the head local flit into one empty channel per cycle, selected by fixed priority or round-robin, and tags it with an XY-routed productive direction.
- Adds the features the single-cycle injector lacks: explicit valid bits instead of high-Z, payload data, a queue, and starvation reporting.

---
 rtl/chipper_pkg.sv | 36 +++
 rtl/chipper_inj_fifo.sv | 57 +++++
 rtl/chipper_injector_param.sv | 164 ++++++++++++++++
 tb/tb_chipper_injector_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chipper_pkg.sv
// Shared constants and XY routing helper for the chipper injection stage.
// Holds direction one-hots, channel indices and the productive-direction function.
package chipper_pkg;

  localparam logic [4:0] DIR_E = 5'b00001;
  localparam logic [4:0] DIR_W = 5'b00010;
  localparam logic [4:0] DIR_N = 5'b00100;
  localparam logic [4:0] DIR_S = 5'b01000;
  localparam logic [4:0] DIR_L = 5'b10000;

  localparam int CH_E = 0;
  localparam int CH_W = 1;
  localparam int CH_N = 2;
  localparam int CH_S = 3;

  // addr is {row, col} zero-extended; cw is the coordinate width.
  function automatic logic [4:0] xy_dir(
    input logic [31:0] addr,
    input logic [31:0] cw,
    input logic [31:0] rx,
    input logic [31:0] ry
  );
    logic [31:0] mask;
    logic [31:0] row;
    logic [31:0] col;
    mask = (32'd1 << cw) - 32'd1;
    col  = addr & mask;
    row  = (addr >> cw) & mask;
    if (col > rx)      xy_dir = DIR_E;
    else if (col < rx) xy_dir = DIR_W;
    else if (row > ry) xy_dir = DIR_N;
    else if (row < ry) xy_dir = DIR_S;
    else               xy_dir = DIR_L;
  endfunction

endpackage

// File: rtl/chipper_inj_fifo.sv
// Synchronous FIFO holding local flits awaiting injection.
// Ports: push/wdata in, pop/rdata head out, full/empty/count status.
module chipper_inj_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/chipper_injector_param.sv
// Deflection-router injection stage: registers NUM_CH channels and injects queued local flits.
// Ports: in_* channels, inj_* local flit, out_* registered channels, out_inj/out_dir, starve, q_count.
module chipper_injector_param
  import chipper_pkg::*;
#(
  parameter int COORD_W      = 3,
  parameter int DATA_W       = 8,
  parameter int NUM_CH       = 4,
  parameter int ROUTER_X     = 4,
  parameter int ROUTER_Y     = 4,
  parameter int QDEPTH       = 4,
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 8,
  localparam int ADDR_W = 2 * COORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*ADDR_W-1:0] in_addr,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     inj_valid,
  output logic                     inj_ready,
  input  logic [ADDR_W-1:0]        inj_addr,
  input  logic [DATA_W-1:0]        inj_data,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*ADDR_W-1:0] out_addr,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_inj,
  output logic [4:0]               out_dir,
  output logic                     starve,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int FW  = ADDR_W + DATA_W;

  logic              full, empty, push, inj, found;
  logic [FW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [NUM_CH-1:0] free, sel_oh;
  logic [PW-1:0]     sel_idx, idx;

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [SCW-1:0]           cnt_q, cnt_d;
  logic                     starve_q, starve_d;
  logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
  logic [NUM_CH*ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0]        out_inj_q, out_inj_d;
  logic [4:0]               out_dir_q, out_dir_d;

  assign inj_ready = !full;
  assign push      = inj_valid && !full;
  assign free      = ~in_valid;
  assign head_addr = head[FW-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

  chipper_inj_fifo #(
    .WIDTH(FW),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({inj_addr, inj_data}),
    .pop   (inj),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // Channel pick: cyclic scan from rr_ptr, or lowest free index.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = '0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = PW'((int'(rr_ptr_q) + k) % NUM_CH);
        if (!found && free[idx]) begin
          found   = 1'b1;
          sel_idx = idx;
        end
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (free[PW'(k)]) begin
          found   = 1'b1;
          sel_idx = PW'(k);
        end
      end
    end
  end

  assign inj = !empty && found;

  always_comb begin
    sel_oh      = '0;
    out_valid_d = in_valid;
    out_addr_d  = in_addr;
    out_data_d  = in_data;
    out_inj_d   = '0;
    out_dir_d   = '0;
    rr_ptr_d    = rr_ptr_q;
    if (inj) begin
      sel_oh[sel_idx] = 1'b1;
      out_inj_d       = sel_oh;
      out_dir_d       = xy_dir(32'(head_addr), 32'(COORD_W),
                               32'(ROUTER_X), 32'(ROUTER_Y));
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_oh[i]) begin
          out_valid_d[i]                 = 1'b1;
          out_addr_d[i*ADDR_W +: ADDR_W] = head_addr;
          out_data_d[i*DATA_W +: DATA_W] = head_data;
        end
      end
      if (RR_MODE != 0) begin
        if (sel_idx == PW'(NUM_CH - 1)) rr_ptr_d = '0;
        else                            rr_ptr_d = sel_idx + PW'(1);
      end
    end
  end

  // Non-empty without injection can only mean every channel is busy.
  always_comb begin
    cnt_d = cnt_q;
    if (empty || inj)                       cnt_d = '0;
    else if (cnt_q != SCW'(STARVE_LIMIT))   cnt_d = cnt_q + SCW'(1);
    starve_d = (cnt_d == SCW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
      out_valid_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_inj_q   <= '0;
      out_dir_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_inj_q   <= out_inj_d;
      out_dir_q   <= out_dir_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_inj   = out_inj_q;
  assign out_dir   = out_dir_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_chipper_injector_param.sv
// Self-checking bench for chipper_injector_param.
// Queue-based reference model checked every cycle plus directed literal checks.
module tb_chipper_injector_param;

  localparam int NCH = 4;
  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int QD  = 4;
  localparam int LIM = 8;
  localparam int RX  = 4;
  localparam int RY  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     in_valid;
  logic [NCH*AW-1:0]  in_addr;
  logic [NCH*DW-1:0]  in_data;
  logic               inj_valid;
  logic               inj_ready;
  logic [AW-1:0]      inj_addr;
  logic [DW-1:0]      inj_data;
  logic [NCH-1:0]     out_valid;
  logic [NCH*AW-1:0]  out_addr;
  logic [NCH*DW-1:0]  out_data;
  logic [NCH-1:0]     out_inj;
  logic [4:0]         out_dir;
  logic               starve;
  logic [2:0]         q_count;

  chipper_injector_param #(
    .COORD_W(3), .DATA_W(DW), .NUM_CH(NCH), .ROUTER_X(RX),
    .ROUTER_Y(RY), .QDEPTH(QD), .RR_MODE(1), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr),
    .in_data(in_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .inj_addr(inj_addr), .inj_data(inj_data), .out_valid(out_valid),
    .out_addr(out_addr), .out_data(out_data), .out_inj(out_inj),
    .out_dir(out_dir), .starve(starve), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } flit_t;

  flit_t          mq[$];
  int             m_rr;
  int             m_cnt;
  bit             started = 0;
  logic [NCH-1:0] e_valid, e_inj;
  logic [NCH*AW-1:0] e_addr;
  logic [NCH*DW-1:0] e_data;
  logic [4:0]     e_dir;
  logic           e_starve;

  function automatic logic [4:0] ref_dir(input logic [AW-1:0] a);
    int row, col;
    row = int'(a[5:3]);
    col = int'(a[2:0]);
    if (col > RX) return 5'b00001;
    if (col < RX) return 5'b00010;
    if (row > RY) return 5'b00100;
    if (row < RY) return 5'b01000;
    return 5'b10000;
  endfunction

  always @(posedge clk) begin : model
    int    sel;
    int    c;
    bit    rdy;
    bit    had;
    flit_t f;
    started = 1;
    if (rst) begin
      mq.delete();
      m_rr = 0; m_cnt = 0;
      e_valid = '0; e_addr = '0; e_data = '0;
      e_inj = '0; e_dir = '0; e_starve = 1'b0;
    end else begin
      rdy = (mq.size() < QD);
      had = (mq.size() > 0);
      e_valid = in_valid; e_addr = in_addr; e_data = in_data;
      e_inj = '0; e_dir = '0;
      sel = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (sel < 0 && !in_valid[c]) sel = c;
      end
      if (had && sel >= 0) begin
        f = mq.pop_front();
        e_valid[sel] = 1'b1;
        e_addr[sel*AW +: AW] = f.a;
        e_data[sel*DW +: DW] = f.d;
        e_inj[sel] = 1'b1;
        e_dir = ref_dir(f.a);
        m_rr = (sel + 1) % NCH;
        m_cnt = 0;
      end else if (!had) begin
        m_cnt = 0;
      end else if (m_cnt < LIM) begin
        m_cnt++;
      end
      e_starve = (m_cnt == LIM);
      if (inj_valid && rdy) begin
        f.a = inj_addr; f.d = inj_data;
        mq.push_back(f);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_valid", 64'(out_valid), 64'(e_valid));
      check("m_addr", 64'(out_addr), 64'(e_addr));
      check("m_data", 64'(out_data), 64'(e_data));
      check("m_inj", 64'(out_inj), 64'(e_inj));
      check("m_dir", 64'(out_dir), 64'(e_dir));
      check("m_starve", 64'(starve), 64'(e_starve));
      check("m_qcount", 64'(q_count), 64'(mq.size()));
      check("m_ready", 64'(inj_ready), 64'(mq.size() < QD));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    inj_valid = 1'b1; inj_addr = a; inj_data = d;
    tick();
    inj_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    in_addr = 24'($urandom);
    in_data = $urandom;
    inj_valid = 1'b0; inj_addr = '0; inj_data = '0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_addr", 64'(out_addr), 64'h0);
    check("rst_inj", 64'(out_inj), 64'h0);
    check("rst_ready", 64'(inj_ready), 64'h1);
    check("rst_qcount", 64'(q_count), 64'h0);
    check("rst_starve", 64'(starve), 64'h0);

    rst = 1'b0;
    in_addr = 24'h123456; in_data = 32'hdeadbeef;
    tick();
    check("mir_valid", 64'(out_valid), 64'hf);
    check("mir_addr", 64'(out_addr), 64'h123456);
    check("mir_data", 64'(out_data), 64'hdeadbeef);
    check("mir_inj", 64'(out_inj), 64'h0);

    // Single injection heading north
    in_valid = 4'b0000;
    push1(6'b101_100, 8'h5a);
    tick();
    check("n_inj", 64'(out_inj), 64'b0001);
    check("n_addr", 64'(out_addr[5:0]), 64'b101100);
    check("n_data", 64'(out_data[7:0]), 64'h5a);
    check("n_dir", 64'(out_dir), 64'b00100);
    check("n_qcount", 64'(q_count), 64'h0);

    // Direction decode; rr pointer now at 1
    push1(6'b100_100, 8'h01); tick();
    check("l_dir", 64'(out_dir), 64'b10000);
    check("l_inj", 64'(out_inj), 64'b0010);
    push1(6'b000_111, 8'h02); tick();
    check("e_dir", 64'(out_dir), 64'b00001);
    check("e_inj", 64'(out_inj), 64'b0100);
    push1(6'b111_000, 8'h03); tick();
    check("w_dir", 64'(out_dir), 64'b00010);
    check("w_inj", 64'(out_inj), 64'b1000);
    tick();
    check("idle_inj", 64'(out_inj), 64'h0);
    check("idle_dir", 64'(out_dir), 64'h0);

    // Fill queue while blocked, refuse a 5th, then drain round-robin
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) push1(6'(8 * i + 1), 8'(8'h10 + i));
    check("full_qcount", 64'(q_count), 64'h4);
    check("full_ready", 64'(inj_ready), 64'h0);
    push1(6'b110_110, 8'hee);
    check("full_hold", 64'(q_count), 64'h4);
    in_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_inj", 64'(out_inj), 64'(4'b0001 << i));
      check("rr_data", 64'(out_data[i*DW +: DW]), 64'(8'h10 + i));
    end
    check("rr_qcount", 64'(q_count), 64'h0);
    tick();
    check("rr_no5th", 64'(out_inj), 64'h0);

    // Starvation
    in_valid = 4'b1111;
    push1(6'b100_000, 8'h77);
    for (int i = 0; i < 7; i++) tick();
    check("stv_lo", 64'(starve), 64'h0);
    tick();
    check("stv_hi", 64'(starve), 64'h1);
    tick(); tick();
    check("stv_sat", 64'(starve), 64'h1);
    in_valid = 4'b1011;
    tick();
    check("stv_inj", 64'(out_inj), 64'b0100);
    check("stv_clr", 64'(starve), 64'h0);

    // Reset with flits queued
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) push1(6'(i + 2), 8'(i + 8'h30));
    check("pre_qcount", 64'(q_count), 64'h3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rq_qcount", 64'(q_count), 64'h0);
    check("rq_valid", 64'(out_valid), 64'h0);
    in_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rq_nostale", 64'(out_inj), 64'h0);
    end

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      in_valid  = 4'($urandom);
      in_addr   = 24'($urandom);
      in_data   = $urandom;
      inj_valid = 1'($urandom_range(0, 1));
      inj_addr  = 6'($urandom);
      inj_data  = 8'($urandom);
      tick();
    end
    inj_valid = 1'b0;
    in_valid = 4'b0000;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
